// File: rtl/lightbike_pkg.sv
// Shared lightbike constants: orientation codes, screen geometry,
// motion FSM state encoding and the turn-request type.
package lightbike_pkg;

    localparam logic [1:0] ORIENT_UP    = 2'b00;
    localparam logic [1:0] ORIENT_RIGHT = 2'b01;
    localparam logic [1:0] ORIENT_DOWN  = 2'b10;
    localparam logic [1:0] ORIENT_LEFT  = 2'b11;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int SPRITE = 30;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_RUN    = 3'd1;
    localparam state_t S_STEP   = 3'd2;
    localparam state_t S_COMMIT = 3'd3;
    localparam state_t S_CRASH  = 3'd4;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'd0,
        TURN_LEFT  = 2'd1,
        TURN_RIGHT = 2'd2
    } turn_t;

endpackage

// File: rtl/bike_motion_ctrl_if.sv
// Control and pose signals exchanged between a game front end and
// the bike motion controller.
interface bike_motion_ctrl_if;
    logic        vs;
    logic        start;
    logic        pause;
    logic        turn_left;
    logic        turn_right;
    logic [31:0] bluebike;
    logic        crash;
    logic        running;

    modport master (
        output vs, start, pause, turn_left, turn_right,
        input  bluebike, crash, running
    );

    modport slave (
        input  vs, start, pause, turn_left, turn_right,
        output bluebike, crash, running
    );
endinterface

// File: rtl/xy_to_addr.sv
// Sprite top-left (x,y) to linear 640-wide frame address, y*640+x,
// built from shifts so it stays a pure adder tree.
module xy_to_addr (
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    output logic [18:0] loc
);
    assign loc = {1'b0, y, 9'b0} + {3'b000, y, 7'b0} + {9'b0, x};
endmodule

// File: rtl/bike_motion_ctrl.sv
// Bike motion controller: advances the sprite once every FRAMES_PER_STEP
// vsync falls and publishes the committed pose during vblank.
module bike_motion_ctrl
    import lightbike_pkg::*;
#(
    parameter int         STEP            = 2,
    parameter int         FRAMES_PER_STEP = 2,
    parameter int         START_X         = 305,
    parameter int         START_Y         = 225,
    parameter logic [1:0] START_ORIENT    = 2'b01
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic        iStart,
    input  logic        iPause,
    input  logic        iTurnLeft,
    input  logic        iTurnRight,
    output logic [31:0] bluebike,
    output logic        oCrash,
    output logic        oRunning
);
    localparam int                 CNT_W     = $clog2(FRAMES_PER_STEP) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [9:0]         START_X_V = 10'(START_X);
    localparam logic [8:0]         START_Y_V = 9'(START_Y);
    localparam logic [18:0]        START_LOC = 19'(START_Y * H_RES + START_X);
    localparam logic signed [11:0] STEP_S    = 12'(STEP);
    localparam logic signed [11:0] X_LIM     = 12'(H_RES - SPRITE);
    localparam logic signed [11:0] Y_LIM     = 12'(V_RES - SPRITE);

    state_t             state;
    logic               vs_q;
    logic               tick;
    logic [CNT_W-1:0]   cnt;
    logic [9:0]         x;
    logic [8:0]         y;
    logic [1:0]         orient;
    logic [1:0]         new_orient;
    turn_t              pending;
    turn_t              req;
    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic               off_screen;
    logic [18:0]        loc;

    assign tick     = vs_q & ~iVS;
    assign oCrash   = (state == S_CRASH);
    assign oRunning = (state == S_RUN) || (state == S_STEP) || (state == S_COMMIT);

    xy_to_addr u_addr (
        .x   (x),
        .y   (y),
        .loc (loc)
    );

    // Simultaneous left+right cancels out rather than picking a winner.
    always_comb begin
        req = TURN_NONE;
        if (iTurnLeft && !iTurnRight) begin
            req = TURN_LEFT;
        end else if (iTurnRight && !iTurnLeft) begin
            req = TURN_RIGHT;
        end
    end

    always_comb begin
        new_orient = orient;
        if (pending == TURN_LEFT) begin
            new_orient = orient - 2'd1;
        end else if (pending == TURN_RIGHT) begin
            new_orient = orient + 2'd1;
        end
        nx = $signed({2'b00, x});
        ny = $signed({3'b000, y});
        case (new_orient)
            ORIENT_UP:    ny = ny - STEP_S;
            ORIENT_RIGHT: nx = nx + STEP_S;
            ORIENT_DOWN:  ny = ny + STEP_S;
            default:      nx = nx - STEP_S;
        endcase
        off_screen = (nx < 12'sd0) || (nx > X_LIM) || (ny < 12'sd0) || (ny > Y_LIM);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= S_IDLE;
            vs_q     <= 1'b1;
            cnt      <= '0;
            x        <= START_X_V;
            y        <= START_Y_V;
            orient   <= START_ORIENT;
            pending  <= TURN_NONE;
            bluebike <= {11'b0, START_LOC, START_ORIENT};
        end else begin
            vs_q <= iVS;
            case (state)
                S_IDLE: begin
                    if (iStart) state <= S_RUN;
                end
                S_RUN: begin
                    if (req != TURN_NONE) pending <= req;
                    if (tick && !iPause) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_STEP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    orient <= new_orient;
                    // A request seen in this cycle waits for the next step.
                    pending <= req;
                    if (off_screen) begin
                        pending <= TURN_NONE;
                        state   <= S_CRASH;
                    end else begin
                        x     <= nx[9:0];
                        y     <= ny[8:0];
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (req != TURN_NONE) pending <= req;
                    bluebike <= {11'b0, loc, orient};
                    state    <= S_RUN;
                end
                S_CRASH: begin
                    if (iStart) begin
                        x        <= START_X_V;
                        y        <= START_Y_V;
                        orient   <= START_ORIENT;
                        cnt      <= '0;
                        bluebike <= {11'b0, START_LOC, START_ORIENT};
                        state    <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
